// File: rtl/depp_regfile.sv
// Digilent EPP slave exposing host-writable control registers and read-only status registers.
// Optional feature: define DEPP_AUTOINC_EN to post-increment addr_reg after every data cycle.
module depp_regfile #(
  parameter int unsigned NREGS       = 8,
  parameter int unsigned NSTAT       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_astb,
  input  logic                 a_dstb,
  input  logic                 a_write,
  inout  wire  [7:0]           a_db,
  output logic                 a_wait,
  output logic [7:0]           addr_reg,
  output logic [NREGS*8-1:0]   reg_q,
  output logic [NREGS-1:0]     wr_stb,
  input  logic [NSTAT*8-1:0]   status_d
);

  typedef enum logic [2:0] {
    S_RELEASE,
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_HOLD
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] astb_sr, dstb_sr, write_sr;
  logic                   astb_s, dstb_s, write_s;

  logic [7:0] regs [NREGS];
  logic [7:0] data_mux;
  logic [7:0] rd_mux;
  logic [7:0] rd_q;
  logic       rd_hold;
  logic       rd_cycle;
  logic       drive_en;
  logic [7:0] db_out;

  // Strobe synchronisers reset low so a strobe held across reset must first be seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      astb_sr  <= '0;
      dstb_sr  <= '0;
      write_sr <= '1;
    end else begin
      astb_sr  <= {astb_sr[SYNC_STAGES-2:0], a_astb};
      dstb_sr  <= {dstb_sr[SYNC_STAGES-2:0], a_dstb};
      write_sr <= {write_sr[SYNC_STAGES-2:0], a_write};
    end
  end

  assign astb_s  = astb_sr[SYNC_STAGES-1];
  assign dstb_s  = dstb_sr[SYNC_STAGES-1];
  assign write_s = write_sr[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RELEASE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RELEASE: if (astb_s && dstb_s) state_nxt = S_IDLE;
      S_IDLE: begin
        if (!astb_s) begin
          state_nxt = S_ADDR;
        end else if (!dstb_s) begin
          state_nxt = S_DATA;
        end
      end
      S_ADDR:    state_nxt = S_HOLD;
      S_DATA:    state_nxt = S_HOLD;
      S_HOLD:    if (astb_s && dstb_s) state_nxt = S_RELEASE;
      default:   state_nxt = S_RELEASE;
    endcase
  end

  always_comb begin
    a_wait   = (state == S_HOLD);
    rd_cycle = ((state == S_ADDR) || (state == S_DATA)) && write_s;
    drive_en = rd_cycle || ((state == S_HOLD) && rd_hold);
  end

  always_comb begin
    data_mux = '0;
    for (int unsigned k = 0; k < NREGS; k++) begin
      if (addr_reg == 8'(k)) data_mux = regs[k];
    end
    for (int unsigned j = 0; j < NSTAT; j++) begin
      if (addr_reg == 8'(NREGS + j)) data_mux = status_d[8*j +: 8];
    end
  end

  always_comb begin
    rd_mux = (state == S_ADDR) ? addr_reg : data_mux;
  end

  // Read data is driven combinationally during the ADDR/DATA cycle and from the latch during HOLD,
  // giving the host one clock of setup before a_wait rises.
  always_comb begin
    db_out = (state == S_HOLD) ? rd_q : rd_mux;
  end

  assign a_db = drive_en ? db_out : 8'hzz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
      wr_stb   <= '0;
      rd_q     <= '0;
      rd_hold  <= 1'b0;
      for (int unsigned k = 0; k < NREGS; k++) begin
        regs[k] <= '0;
      end
    end else begin
      wr_stb <= '0;
      if (state == S_ADDR) begin
        rd_hold <= write_s;
        rd_q    <= rd_mux;
        if (!write_s) addr_reg <= a_db;
      end
      if (state == S_DATA) begin
        rd_hold <= write_s;
        rd_q    <= rd_mux;
        if (!write_s) begin
          for (int unsigned k = 0; k < NREGS; k++) begin
            if (addr_reg == 8'(k)) begin
              regs[k]   <= a_db;
              wr_stb[k] <= 1'b1;
            end
          end
        end
`ifdef DEPP_AUTOINC_EN
        addr_reg <= addr_reg + 8'd1;
`endif
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned k = 0; k < NREGS; k++) begin
      reg_q[8*k +: 8] = regs[k];
    end
  end

endmodule

// File: tb/tb_depp_regfile.sv
// Scoreboard bench for depp_regfile: host-side EPP transfers against a byte-level register model.
module tb_depp_regfile;

  localparam int unsigned NREGS = 8;
  localparam int unsigned NSTAT = 4;
  localparam int unsigned SYNC  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 a_astb, a_dstb, a_write;
  wire  [7:0]           a_db;
  logic                 a_wait;
  logic [7:0]           addr_reg;
  logic [NREGS*8-1:0]   reg_q;
  logic [NREGS-1:0]     wr_stb;
  logic [NSTAT*8-1:0]   status_d;

  logic       host_en;
  logic [7:0] host_data;
  assign a_db = host_en ? host_data : 8'hzz;

  depp_regfile #(.NREGS(NREGS), .NSTAT(NSTAT), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_astb   (a_astb),
    .a_dstb   (a_dstb),
    .a_write  (a_write),
    .a_db     (a_db),
    .a_wait   (a_wait),
    .addr_reg (addr_reg),
    .reg_q    (reg_q),
    .wr_stb   (wr_stb),
    .status_d (status_d)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] rd_q[$];

  logic [7:0] m_regs [NREGS];
  logic [7:0] m_addr;

  function automatic logic [63:0] model_vec();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < NREGS; k++) v[8*k +: 8] = m_regs[k];
    return v;
  endfunction

  // Output monitors: pop expectations when the DUT produces a write pulse or completes a read.
  logic       prev_wait = 1'b0;
  logic [7:0] prev_db   = '0;
  always @(negedge clk) begin
    if (rst_n && wr_stb != '0) begin
      if (wr_q.size() == 0) begin
        check("wr_spurious", 64'(wr_stb), 64'd0);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_stb", 64'(wr_stb), 64'd1 << e.addr);
        check("reg_q_byte", 64'(reg_q[e.addr*8 +: 8]), 64'(e.data));
      end
    end
    if (a_wait && !prev_wait && a_write) begin
      if (rd_q.size() == 0) begin
        check("rd_queue", 64'(rd_q.size()), 64'd1);
      end else begin
        logic [7:0] x;
        x = rd_q.pop_front();
        check("rd_setup", 64'(prev_db), 64'(x));
        check("rd_data", 64'(a_db), 64'(x));
      end
    end
    prev_wait = a_wait;
    prev_db   = a_db;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic xfer(input bit as, input bit ds, input bit rd, input logic [7:0] wd);
    int n;
    a_write   = rd;
    host_data = wd;
    host_en   = !rd;
    if (as) a_astb = 1'b0;
    if (ds) a_dstb = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!a_wait && n < 40);
    check("wait_rise_lat", 64'(n), 64'(SYNC + 2));
    a_astb  = 1'b1;
    a_dstb  = 1'b1;
    host_en = 1'b0;
    n = 0;
    do begin tick(); n++; end while (a_wait && n < 40);
    check("wait_fall_lat", 64'(n), 64'(SYNC + 1));
    if (rd) begin
      host_en   = 1'b1;
      host_data = 8'h3C;
      #1;
      check("bus_release", 64'(a_db), 64'h3C);
      host_en = 1'b0;
    end
    tick();
    check("addr_reg", 64'(addr_reg), 64'(m_addr));
  endtask

  task automatic addr_wr(input logic [7:0] a);
    m_addr = a;
    xfer(1, 0, 0, a);
  endtask

  task automatic addr_rd();
    rd_q.push_back(m_addr);
    xfer(1, 0, 1, 8'h00);
  endtask

  task automatic data_wr(input logic [7:0] d);
    wr_t e;
    if (m_addr < NREGS) begin
      e.addr = m_addr;
      e.data = d;
      wr_q.push_back(e);
      m_regs[m_addr[2:0]] = d;
    end
`ifdef DEPP_AUTOINC_EN
    m_addr = m_addr + 8'd1;
`endif
    xfer(0, 1, 0, d);
  endtask

  task automatic data_rd();
    logic [7:0] x;
    if (m_addr < NREGS) x = m_regs[m_addr[2:0]];
    else if (m_addr < NREGS + NSTAT) x = status_d[(m_addr - NREGS)*8 +: 8];
    else x = 8'h00;
    rd_q.push_back(x);
`ifdef DEPP_AUTOINC_EN
    m_addr = m_addr + 8'd1;
`endif
    xfer(0, 1, 1, 8'h00);
  endtask

  initial begin
    rst_n     = 1'b0;
    a_astb    = 1'b0;
    a_dstb    = 1'b1;
    a_write   = 1'b0;
    host_en   = 1'b0;
    host_data = '0;
    status_d  = 32'hD3C2_5CA0;
    m_addr    = '0;
    for (int k = 0; k < NREGS; k++) m_regs[k] = '0;

    repeat (3) tick();
    check("rst_a_wait", 64'(a_wait), 64'd0);
    check("rst_addr", 64'(addr_reg), 64'd0);
    check("rst_reg_q", reg_q, 64'd0);
    check("rst_wr_stb", 64'(wr_stb), 64'd0);

    // Strobe held low across reset release must not start a transfer.
    rst_n = 1'b1;
    repeat (20) tick();
    check("held_strobe_wait", 64'(a_wait), 64'd0);
    check("held_strobe_addr", 64'(addr_reg), 64'd0);
    a_astb = 1'b1;
    repeat (5) tick();

    addr_wr(8'h03);
    data_wr(8'hA5);
    check("reg3", 64'(reg_q[31:24]), 64'hA5);
    addr_wr(8'h03);
    data_rd();

    addr_wr(8'h07);
    addr_rd();

    for (int k = 0; k < NREGS; k++) begin
      addr_wr(8'(k));
      data_wr(8'(k * 17) ^ 8'h5A);
    end
    for (int k = NREGS - 1; k >= 0; k--) begin
      addr_wr(8'(k));
      data_rd();
    end
    check("reg_vec", reg_q, model_vec());

    for (int j = 0; j < NSTAT; j++) begin
      addr_wr(8'(NREGS + j));
      data_rd();
    end
    status_d[15:8] = 8'h5C;
    addr_wr(8'd9);
    data_rd();
    status_d[15:8] = 8'h96;
    addr_wr(8'd9);
    data_rd();

    addr_wr(8'h40);
    data_rd();
    addr_wr(8'h40);
    data_wr(8'hEE);
    check("unmapped_wr", reg_q, model_vec());

    // Both strobes together: address wins, registers untouched.
    m_addr = 8'h02;
    xfer(1, 1, 0, 8'h02);
    check("both_strobe_regs", reg_q, model_vec());

`ifdef DEPP_AUTOINC_EN
    addr_wr(8'hFF);
    data_wr(8'h11);
    check("autoinc_wrap", 64'(addr_reg), 64'h00);
    data_wr(8'h22);
    check("autoinc_next", 64'(addr_reg), 64'h01);
    check("autoinc_reg0", 64'(reg_q[7:0]), 64'h22);
`else
    addr_wr(8'h05);
    data_wr(8'h3E);
    data_wr(8'h3F);
    check("no_autoinc_reg5", 64'(reg_q[47:40]), 64'h3F);
`endif

    // Reset pulse during HOLD of a read.
    addr_wr(8'h01);
    rd_q.push_back(m_regs[1]);
    a_write = 1'b1;
    a_dstb  = 1'b0;
    begin
      int n;
      n = 0;
      do begin tick(); n++; end while (!a_wait && n < 40);
      check("hold_reached", 64'(a_wait), 64'd1);
    end
    rst_n = 1'b0;
    #1;
    check("rst_hold_wait", 64'(a_wait), 64'd0);
    host_en   = 1'b1;
    host_data = 8'h3C;
    #1;
    check("rst_hold_bus", 64'(a_db), 64'h3C);
    host_en = 1'b0;
    m_addr  = '0;
    for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("post_rst_wait", 64'(a_wait), 64'd0);
    check("post_rst_regs", reg_q, 64'd0);
    a_dstb = 1'b1;
    repeat (5) tick();

    addr_wr(8'h05);
    data_wr(8'h77);
    addr_wr(8'h05);
    data_rd();
    check("final_regs", reg_q, model_vec());

    repeat (4) tick();
    check("sb_wr_drain", 64'(wr_q.size()), 64'd0);
    check("sb_rd_drain", 64'(rd_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
